// File: rtl/datapath_arbiter.sv
// rtl/datapath_arbiter.sv - round-robin arbiter sharing one ALU/GCD datapath between requesters
module datapath_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int WIDTH          = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*4-1:0] req_opcode,
  input  logic [NUM_REQ*8-1:0] req_a,
  input  logic [NUM_REQ*8-1:0] req_b,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [WIDTH-1:0]     rsp_result,
  output logic                 rsp_error,
  output logic                 busy,
  output logic                 dp_enable,
  output logic [3:0]           dp_opcode,
  output logic [7:0]           dp_a,
  output logic [7:0]           dp_b,
  input  logic                 dp_done,
  input  logic [WIDTH-1:0]     dp_result
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESPOND} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [3:0]         opcode_q, opcode_d;
  logic [7:0]         a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               err_q, err_d;
  logic [WD_W-1:0]    wdog_q, wdog_d;
  logic [IDX_W-1:0]   winner, cand;
  logic               found;
  logic [3:0]         win_opcode;
  logic [NUM_REQ-1:0] idx_onehot;

  function automatic logic opcode_valid(input logic [3:0] op);
    return (op == 4'b0001) || (op == 4'b0010) || (op == 4'b0011) || (op == 4'b1011);
  endfunction

  // First set request at or above rr_ptr_q, wrapping around
  always_comb begin
    winner = '0;
    cand   = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign win_opcode = req_opcode[int'(winner)*4 +: 4];

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    idx_d    = idx_q;
    opcode_d = opcode_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    err_d    = err_q;
    wdog_d   = wdog_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          idx_d    = winner;
          opcode_d = win_opcode;
          a_d      = req_a[int'(winner)*8 +: 8];
          b_d      = req_b[int'(winner)*8 +: 8];
          result_d = '0;
          wdog_d   = '0;
          // Invalid opcodes skip the datapath and answer with an error directly
          if (opcode_valid(win_opcode)) begin
            err_d   = 1'b0;
            state_d = BUSY;
          end else begin
            err_d   = 1'b1;
            state_d = RESPOND;
          end
        end
      end
      BUSY: begin
        wdog_d = wdog_q + 1'b1;
        if (dp_done) begin
          result_d = dp_result;
          err_d    = 1'b0;
          state_d  = RESPOND;
        end else if (wdog_q == WD_LAST) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = RESPOND;
        end
      end
      RESPOND: begin
        rr_ptr_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      idx_q    <= '0;
      opcode_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      wdog_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      idx_q    <= idx_d;
      opcode_q <= opcode_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      err_q    <= err_d;
      wdog_q   <= wdog_d;
    end
  end

  always_comb begin
    idx_onehot        = '0;
    idx_onehot[idx_q] = 1'b1;
  end

  assign gnt        = (state_q != IDLE) ? idx_onehot : '0;
  assign rsp_valid  = (state_q == RESPOND) ? idx_onehot : '0;
  assign rsp_result = (state_q == RESPOND) ? result_q : '0;
  assign rsp_error  = (state_q == RESPOND) && err_q;
  assign busy       = (state_q != IDLE);
  assign dp_enable  = (state_q == BUSY);
  assign dp_opcode  = opcode_q;
  assign dp_a       = a_q;
  assign dp_b       = b_q;

endmodule

// File: tb/tb_datapath_arbiter.sv
// tb/tb_datapath_arbiter.sv - randomized self-checking bench for datapath_arbiter
module tb_datapath_arbiter;
  localparam int N  = 2;
  localparam int W  = 16;
  localparam int TO = 4;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*4-1:0] req_opcode = '0;
  logic [N*8-1:0] req_a = '0;
  logic [N*8-1:0] req_b = '0;
  logic [N-1:0]   gnt, rsp_valid;
  logic [W-1:0]   rsp_result;
  logic           rsp_error, busy, dp_enable;
  logic [3:0]     dp_opcode;
  logic [7:0]     dp_a, dp_b;
  logic           dp_done = 1'b0;
  logic [W-1:0]   dp_result = '0;

  int n_checks = 0;
  int n_pass   = 0;
  int m_rr     = 0;
  int dp_lat   = 1;
  bit dp_hang  = 1'b0;
  int en_cnt   = 0;
  int low_cnt  = 0;
  bit en_prev  = 1'b0;
  bit seen_en  = 1'b0;

  datapath_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_opcode(req_opcode),
    .req_a(req_a), .req_b(req_b), .gnt(gnt), .rsp_valid(rsp_valid),
    .rsp_result(rsp_result), .rsp_error(rsp_error), .busy(busy),
    .dp_enable(dp_enable), .dp_opcode(dp_opcode), .dp_a(dp_a), .dp_b(dp_b),
    .dp_done(dp_done), .dp_result(dp_result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [W-1:0] alu_ref(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [W-1:0] x, y, t;
    case (op)
      4'b0001: return W'(a) + W'(b);
      4'b0010: return W'(a) - W'(b);
      4'b0011: return W'(a) * W'(b);
      4'b1011: begin
        x = W'(a);
        y = W'(b);
        while (y != 0) begin
          t = x % y;
          x = y;
          y = t;
        end
        return x;
      end
      default: return '0;
    endcase
  endfunction

  function automatic bit op_ok(input logic [3:0] op);
    return op inside {4'h1, 4'h2, 4'h3, 4'hB};
  endfunction

  // Datapath stand-in: done after dp_lat enabled cycles unless hung; result is noise otherwise
  always @(negedge clk) begin
    if (dp_enable) begin
      en_cnt    <= en_cnt + 1;
      dp_done   <= !dp_hang && (en_cnt + 1 == dp_lat);
      dp_result <= (!dp_hang && (en_cnt + 1 == dp_lat)) ? alu_ref(dp_opcode, dp_a, dp_b) : W'($urandom);
    end else begin
      en_cnt    <= 0;
      dp_done   <= 1'b0;
      dp_result <= W'($urandom);
    end
  end

  always @(negedge clk) begin
    if (dp_enable) begin
      if (!en_prev && seen_en) check("en_low_gap_ge2", 32'(low_cnt >= 2), 32'd1);
      seen_en <= 1'b1;
      low_cnt <= 0;
    end else begin
      low_cnt <= low_cnt + 1;
    end
    en_prev <= dp_enable;
  end

  task automatic run_op(input logic [N-1:0] mask, input int lat, input bit hang, input bit scramble);
    int w, n, ens, exp_n;
    logic [3:0] op;
    logic [7:0] a, b;
    bit ok, err, got_rsp;
    logic [W-1:0] res;
    @(posedge clk);
    #2;
    req     = mask;
    dp_lat  = lat;
    dp_hang = hang;
    w = -1;
    for (int k = 0; k < N; k++)
      if (w < 0 && mask[(m_rr + k) % N]) w = (m_rr + k) % N;
    op    = req_opcode[w*4 +: 4];
    a     = req_a[w*8 +: 8];
    b     = req_b[w*8 +: 8];
    ok    = op_ok(op);
    err   = !ok || hang || (lat > TO);
    res   = err ? '0 : alu_ref(op, a, b);
    exp_n = !ok ? 2 : (err ? TO + 2 : lat + 2);
    n = 0; ens = 0; got_rsp = 1'b0;
    while (!got_rsp && n < 20) begin
      @(negedge clk);
      n++;
      if (rsp_valid != 0) begin
        got_rsp = 1'b1;
      end else begin
        check("gnt", 32'(gnt), (n == 1) ? 32'd0 : (32'd1 << w));
        if (dp_enable) begin
          ens++;
          check("dp_opcode", 32'(dp_opcode), 32'(op));
          check("dp_a", 32'(dp_a), 32'(a));
          check("dp_b", 32'(dp_b), 32'(b));
        end
        @(posedge clk);
        #2;
        if (scramble && n >= 2) req_a[w*8 +: 8] = 8'($urandom);
      end
    end
    check("rsp_seen", 32'(got_rsp), 32'd1);
    check("rsp_cycle", 32'(n), 32'(exp_n));
    check("rsp_valid", 32'(rsp_valid), 32'd1 << w);
    check("gnt_in_rsp", 32'(gnt), 32'd1 << w);
    check("rsp_result", 32'(rsp_result), 32'(res));
    check("rsp_error", 32'(rsp_error), 32'(err));
    check("busy_in_rsp", 32'(busy), 32'd1);
    check("en_cycles", 32'(ens), ok ? (err ? 32'(TO) : 32'(lat)) : 32'd0);
    m_rr = (w + 1) % N;
  endtask

  initial begin
    logic [3:0] vops [4];
    logic [N-1:0] mask;
    int sel;
    vops = '{4'h1, 4'h2, 4'h3, 4'hB};
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dp_enable", 32'(dp_enable), 32'd0);
    check("rst_dp_opcode", 32'(dp_opcode), 32'd0);
    check("rst_dp_a", 32'(dp_a), 32'd0);
    check("rst_dp_b", 32'(dp_b), 32'd0);
    check("rst_rsp_result", 32'(rsp_result), 32'd0);
    check("rst_rsp_error", 32'(rsp_error), 32'd0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;

    // Contention: both held for four ops, grants alternate from requester 0
    req_opcode = {4'h3, 4'h1};
    req_a      = {8'd12, 8'd200};
    req_b      = {8'd11, 8'd100};
    for (int i = 0; i < 4; i++) run_op(2'b11, 2, 1'b0, 1'b0);

    req_opcode[3:0] = 4'h1; req_a[7:0] = 8'd5; req_b[7:0] = 8'd3;
    run_op(2'b01, 2, 1'b0, 1'b0);

    req_opcode[7:4] = 4'h7;
    run_op(2'b10, 1, 1'b0, 1'b0);
    req_opcode[7:4] = 4'hF;
    run_op(2'b10, 1, 1'b0, 1'b0);

    req_opcode[3:0] = 4'hB; req_a[7:0] = 8'd48; req_b[7:0] = 8'd36;
    run_op(2'b01, 1, 1'b1, 1'b0);
    run_op(2'b01, TO, 1'b0, 1'b0);
    run_op(2'b01, TO + 1, 1'b0, 1'b0);

    req_opcode[3:0] = 4'h1; req_a[7:0] = 8'd77; req_b[7:0] = 8'd9;
    run_op(2'b01, 3, 1'b0, 1'b1);

    // Reset while requester 0's op is stuck in the datapath
    req_opcode[3:0] = 4'h2;
    @(posedge clk);
    #2;
    dp_hang = 1'b1;
    req = 2'b01;
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    req = '0;
    @(negedge clk);
    check("pre_rst_enable", 32'(dp_enable), 32'd1);
    check("pre_rst_rsp", 32'(rsp_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_rst_rsp", 32'(rsp_valid), 32'd0);
      check("mid_rst_gnt", 32'(gnt), 32'd0);
      check("mid_rst_enable", 32'(dp_enable), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
    end
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    dp_hang = 1'b0;
    m_rr = 0;
    req_opcode = {4'h1, 4'h3};
    run_op(2'b11, 2, 1'b0, 1'b0);

    for (int it = 0; it < 40; it++) begin
      for (int r = 0; r < N; r++) begin
        sel = $urandom_range(0, 9);
        req_opcode[r*4 +: 4] = (sel < 8) ? vops[sel % 4] : 4'($urandom);
        req_a[r*8 +: 8] = 8'($urandom);
        req_b[r*8 +: 8] = 8'($urandom);
      end
      mask = N'($urandom_range(1, (1 << N) - 1));
      run_op(mask, $urandom_range(1, TO + 1), ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)));
    end

    @(posedge clk);
    #2;
    req = '0;
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
